// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the shared 4:1 32-bit datapath mux.
// Grants one requester for up to BURST_MAX valid/ready beats, then forces an idle bubble.
module mux_rr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [3:0]        req_i,
  input  logic [DATA_W-1:0] src0_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [DATA_W-1:0] src3_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        select_o,
  output logic [3:0]        gnt_o,
  output logic [3:0]        ack_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_select, w_select_nxt;
  logic [3:0]  r_gnt, w_gnt_nxt;
  logic [3:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic [1:0]  r_last, w_last_nxt;

  logic [1:0]  w_winner;
  logic        w_found;
  logic [1:0]  w_cand;
  logic        w_valid;
  logic        w_xfer;

  // Scan last+1, last+2, ... so the most recently served requester ranks lowest.
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_cand = r_last + k[1:0];
      if (!w_found && req_i[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_valid = (|r_gnt) & req_i[r_select];
  assign w_xfer  = w_valid & out_ready_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_select_nxt   = r_select;
    w_gnt_nxt      = r_gnt;
    w_beat_cnt_nxt = r_beat_cnt;
    w_last_nxt     = r_last;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_select_nxt   = w_winner;
          w_gnt_nxt      = 4'b0001 << w_winner;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (!req_i[r_select] ||
            (w_xfer && (r_beat_cnt + 4'd1 == 4'(BURST_MAX)))) begin
          w_last_nxt  = r_select;
          w_gnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_select   <= '0;
      r_gnt      <= '0;
      r_beat_cnt <= '0;
      r_last     <= 2'd3;
    end else begin
      r_state    <= w_state_nxt;
      r_select   <= w_select_nxt;
      r_gnt      <= w_gnt_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_last     <= w_last_nxt;
    end
  end

  always_comb begin
    case (r_select)
      2'd0:    out_data_o = src0_i;
      2'd1:    out_data_o = src1_i;
      2'd2:    out_data_o = src2_i;
      default: out_data_o = src3_i;
    endcase
  end

  assign out_valid_o = w_valid;
  assign ack_o       = r_gnt & req_i & {4{out_ready_i}};
  assign select_o    = r_select;
  assign gnt_o       = r_gnt;

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's shared 4-to-1 32-bit datapath mux.
- Up to four requesters present 32-bit beats. The block picks one requester and drives the 2-bit mux select for it.
- The selected requester's data is streamed downstream over a valid/ready handshake, in bursts of up to BURST_MAX beats.
- Sits between the requesting pipeline stages and a single consumer port; it replaces any hard-wired select logic.

Parameters:
- DATA_W, 32, width of each source and of the output data.
- BURST_MAX, 4, maximum beats per grant before forced release; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- req_i  input  4  per-requester request; bit k = requester k has a beat.
- src0_i  input  DATA_W  requester 0 data.
- src1_i  input  DATA_W  requester 1 data.
- src2_i  input  DATA_W  requester 2 data.
- src3_i  input  DATA_W  requester 3 data.
- out_ready_i  input  1  consumer can accept a beat this cycle.
- out_valid_o  output  1  out_data_o holds a valid beat.
- out_data_o  output  DATA_W  selected source data; combinational through the 4:1 select.
- select_o  output  2  registered mux select (00..11 = requester 0..3).
- gnt_o  output  4  registered one-hot grant; all zero when idle.
- ack_o  output  4  one-hot; bit k high in the cycle a beat from requester k transfers.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - state = IDLE; select_o = 2'b00; gnt_o = 0; beat_cnt = 0.
  - Priority pointer last_q = 3, so requester 0 has highest priority after reset.
  - out_valid_o = 0 and ack_o = 0, since both derive from gnt_o.
  - Reset asserted mid-burst abandons the burst immediately. No ack is issued in the reset cycle.
- States: IDLE and GRANT.
- IDLE, when req_i != 0 at a rising edge:
  - Winner = first set bit scanning last_q+1, last_q+2, ... modulo 4.
  - select_o <= winner; gnt_o <= one-hot(winner); beat_cnt <= 0; go to GRANT.
  - Arbitration latency is exactly 1 cycle from request to gnt_o.
- IDLE, when req_i == 0: stay in IDLE; outputs hold their reset-style values.
- GRANT, combinational outputs (s = select_o):
  - out_valid_o = req_i[s].
  - ack_o[s] = req_i[s] & out_ready_i; all other ack bits are 0.
- GRANT, beat accounting: a beat transfers when out_valid_o & out_ready_i; beat_cnt then increments.
- GRANT, release conditions, evaluated at the rising edge:
  - (a) req_i[s] low, whether or not out_ready_i is high.
  - (b) A beat transfers and beat_cnt+1 == BURST_MAX.
- GRANT, on release: last_q <= s; gnt_o <= 0; select_o holds its value; go to IDLE. One mandatory idle bubble follows every grant.
- GRANT, otherwise: stay in GRANT; select_o and gnt_o are stable.
- Back-pressure (out_ready_i low): no transfer, beat_cnt holds, grant held. A requester keeping req high cannot be preempted until BURST_MAX beats transfer.
- Requests from other requesters during GRANT are ignored until the return to IDLE. Changing req bits is always safe.
- out_data_o = src[select_o] at all times, with no register. It is don't-care while out_valid_o is low.
- beat_cnt is 4 bits wide and never exceeds BURST_MAX-1 in GRANT.
- BURST_MAX = 1 releases after every transferred beat.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,... Each grant lasts BURST_MAX transfer cycles plus one idle cycle.
- No combinational path from req_i to select_o or gnt_o. There are combinational paths req_i/out_ready_i -> out_valid_o/ack_o.

Test Plan:
1. Reset, then req_i=4'b0101, out_ready_i=1, BURST_MAX=4.
   - gnt_o=0001 one cycle later; 4 acks to requester 0.
   - Then 1 idle cycle; then gnt_o=0100, select_o=2'b10, 4 acks.
   - Then gnt_o=0001 again.
2. All four requesting continuously, out_ready_i=1.
   - Grant order 0,1,2,3,0.
   - Each grant spans exactly 4 transfers plus 1 idle cycle (20 cycles per rotation).
   - out_data_o matches src of select_o on every ack.
3. Requester 2 alone; out_ready_i toggles 1,0,0,1,1,0,1.
   - Acks only on ready-high cycles.
   - Release after the 4th ack; beat_cnt holds while ready is low.
4. Requester 1 granted; req_i[1] drops after 2 acks while req_i[3] is high.
   - Release on that cycle with no extra ack.
   - Idle cycle, then gnt_o=1000, select_o=2'b11.
5. Assert rst_n_i low mid-burst, asynchronously between edges.
   - gnt_o, ack_o and out_valid_o go to 0 immediately; select_o=00.
   - After release of reset with req_i=4'b1010, requester 1 wins first.
6. BURST_MAX=1, req_i=4'b0011, ready=1.
   - Alternating grants 0,1,0,1, each with one ack and one idle cycle between.
